// File: rtl/adder_tree_scheduler.sv
// Round-robin scheduler that time-shares one external adder tree between two requesters,
// accumulating PASSES beats per job into a single result.
module adder_tree_scheduler #(
    parameter  int data_depth = 8,
    parameter  int ArrL       = 4,
    parameter  int PASSES     = 4,
    localparam int sumDepth   = $clog2(ArrL) + data_depth,
    localparam int accDepth   = sumDepth + $clog2(PASSES)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req0_valid,
    input  logic [data_depth*ArrL-1:0] req0_data,
    output logic                       req0_ready,
    input  logic                       req1_valid,
    input  logic [data_depth*ArrL-1:0] req1_data,
    output logic                       req1_ready,
    output logic [data_depth*ArrL-1:0] tree_din,
    input  logic [sumDepth-1:0]        tree_sum,
    output logic                       out_valid,
    output logic [accDepth-1:0]        out_sum,
    output logic                       out_id,
    input  logic                       out_ready
);

    localparam int CNT_W = $clog2(PASSES + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PASSES - 1);

    // state | meaning
    // IDLE  | arbitrate between valid requesters
    // ACCUM | accept PASSES beats from the granted requester
    // DONE  | hold result until out_ready
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 grant_id;
    logic                 grant_nxt;
    logic                 last_id;
    logic [accDepth-1:0]  acc;
    logic [CNT_W-1:0]     beat_cnt;
    logic                 beat_fire;

    assign beat_fire  = (state == ACCUM) && (grant_id ? req1_valid : req0_valid);
    assign req0_ready = (state == ACCUM) && !grant_id;
    assign req1_ready = (state == ACCUM) && grant_id;
    assign tree_din   = (state == ACCUM) ? (grant_id ? req1_data : req0_data) : '0;
    assign out_valid  = (state == DONE);
    assign out_sum    = (state == DONE) ? acc : '0;
    assign out_id     = (state == DONE) && grant_id;

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_id;
        case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    state_nxt = ACCUM;
                    // on a tie, serve whoever was not served last
                    if (req0_valid && req1_valid)
                        grant_nxt = ~last_id;
                    else
                        grant_nxt = req1_valid;
                end
            end
            ACCUM: begin
                if (beat_fire && (beat_cnt == LAST_BEAT))
                    state_nxt = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant_id <= 1'b0;
            last_id  <= 1'b1;
            acc      <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            grant_id <= grant_nxt;
            if (state == IDLE && state_nxt == ACCUM)
                beat_cnt <= '0;
            if (beat_fire) begin
                acc      <= (beat_cnt == '0) ? accDepth'(tree_sum) : acc + accDepth'(tree_sum);
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
            if (state == DONE && out_ready)
                last_id <= grant_id;
        end
    end

endmodule

// File: tb/tb_adder_tree_scheduler.sv
// Directed bench for adder_tree_scheduler at default parameters; the external adder tree
// is modelled combinationally from tree_din.
module tb_adder_tree_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0;
    logic [31:0] req0_data = '0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [31:0] req1_data = '0;
    logic        req1_ready;
    logic [31:0] tree_din;
    logic [9:0]  tree_sum;
    logic        out_valid;
    logic [11:0] out_sum;
    logic        out_id;
    logic        out_ready = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always_comb begin
        tree_sum = '0;
        for (int k = 0; k < 4; k++)
            tree_sum = tree_sum + 10'(tree_din[k*8 +: 8]);
    end

    adder_tree_scheduler dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .tree_din(tree_din), .tree_sum(tree_sum),
        .out_valid(out_valid), .out_sum(out_sum), .out_id(out_id), .out_ready(out_ready)
    );

    function automatic logic [31:0] rep(input logic [7:0] v);
        return {4{v}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 0);
        chk({tag, "_sum"}, 32'(out_sum), 0);
        chk({tag, "_id"}, 32'(out_id), 0);
        chk({tag, "_rdy0"}, 32'(req0_ready), 0);
        chk({tag, "_rdy1"}, 32'(req1_ready), 0);
        chk({tag, "_din"}, tree_din, 0);
    endtask

    initial begin
        // reset state
        step();
        step();
        chk_quiet("reset");
        rst = 1'b0;

        // req0 alone, all elements 0xFF
        req0_valid = 1'b1;
        req0_data  = rep(8'hFF);
        #1;
        chk("idle_no_accept", 32'(req0_ready), 0);
        chk("idle_din_zero", tree_din, 0);
        step();
        chk("j1_rdy0", 32'(req0_ready), 1);
        chk("j1_din", tree_din, 32'hFFFF_FFFF);
        chk("j1_tree_sum", 32'(tree_sum), 1020);
        for (int b = 0; b < 4; b++) begin
            chk("j1_no_early_valid", 32'(out_valid), 0);
            step();
        end
        chk("j1_valid", 32'(out_valid), 1);
        chk("j1_sum", 32'(out_sum), 4080);
        chk("j1_id", 32'(out_id), 0);
        chk("j1_din_done", tree_din, 0);
        req0_valid = 1'b0;
        out_ready  = 1'b1;
        step();
        chk("j1_back_idle", 32'(out_valid), 0);
        out_ready = 1'b0;

        // both valid from reset: req0 wins first tie, then req1
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0_valid = 1'b1;
        req0_data  = rep(8'd1);
        req1_valid = 1'b1;
        req1_data  = rep(8'd5);
        step();
        chk("j2_rdy0", 32'(req0_ready), 1);
        chk("j2_rdy1", 32'(req1_ready), 0);
        for (int b = 1; b <= 4; b++) begin
            req0_data = rep(8'(b));
            #1;
            chk("j2_din_req0", tree_din, rep(8'(b)));
            chk("j2_rdy1_low", 32'(req1_ready), 0);
            step();
        end
        chk("j2_sum", 32'(out_sum), 40);
        chk("j2_id", 32'(out_id), 0);
        out_ready = 1'b1;
        step();
        chk("j3_idle", 32'(out_valid), 0);
        step();
        chk("j3_rdy1", 32'(req1_ready), 1);
        chk("j3_rdy0", 32'(req0_ready), 0);
        for (int b = 0; b < 4; b++) begin
            chk("j3_din_req1", tree_din, rep(8'd5));
            step();
        end
        chk("j3_valid", 32'(out_valid), 1);
        chk("j3_sum", 32'(out_sum), 80);
        chk("j3_id", 32'(out_id), 1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        out_ready = 1'b0;

        // req0 job with a 3-cycle gap after beat 2
        req0_valid = 1'b1;
        req0_data  = rep(8'd10);
        step();
        step();
        req0_data = rep(8'd20);
        step();
        req0_valid = 1'b0;
        req0_data  = rep(8'd99);
        for (int g = 0; g < 3; g++) begin
            chk("gap_rdy0", 32'(req0_ready), 1);
            chk("gap_no_valid", 32'(out_valid), 0);
            step();
        end
        req0_valid = 1'b1;
        req0_data  = rep(8'd30);
        step();
        req0_data = rep(8'd40);
        step();
        req0_valid = 1'b0;
        chk("gap_sum", 32'(out_sum), 400);

        // out_ready held low for 5 cycles in DONE
        for (int h = 0; h < 5; h++) begin
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_sum", 32'(out_sum), 400);
            chk("hold_id", 32'(out_id), 0);
            chk("hold_rdy0", 32'(req0_ready), 0);
            chk("hold_rdy1", 32'(req1_ready), 0);
            step();
        end
        chk("hold_still_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        step();
        chk("hold_released", 32'(out_valid), 0);
        out_ready = 1'b0;

        // reset mid-job, then a tie must go to req0
        req1_valid = 1'b1;
        req1_data  = rep(8'd7);
        step();
        chk("rj_rdy1", 32'(req1_ready), 1);
        step();
        step();
        rst = 1'b1;
        #1;
        chk_quiet("midrst");
        step();
        rst = 1'b0;
        req0_valid = 1'b1;
        req0_data  = rep(8'd2);
        req1_data  = rep(8'd3);
        step();
        chk("post_rst_rdy0", 32'(req0_ready), 1);
        chk("post_rst_rdy1", 32'(req1_ready), 0);
        for (int b = 0; b < 4; b++)
            step();
        chk("post_rst_sum", 32'(out_sum), 32);
        chk("post_rst_id", 32'(out_id), 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        out_ready  = 1'b1;
        step();
        chk("post_rst_idle", 32'(out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_tree_scheduler.md
ADDER_TREE_SCHEDULER -- requirements
Module: adder_tree_scheduler

Interface
REQ-001 Parameter data_depth, default 8, width of one element.
REQ-002 Parameter ArrL, default 4, elements per beat (lane count of the shared adder tree).
REQ-003 Parameter PASSES, default 4, beats per job; PASSES >= 1.
REQ-004 Derived widths SHALL be sumDepth = ceil(log2(ArrL)) + data_depth and accDepth = sumDepth + ceil(log2(PASSES)); for PASSES = 1, accDepth = sumDepth.
REQ-005 Port clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-006 Port rst  in  1  asynchronous, active-high reset.
REQ-007 Port req0_valid  in  1  requester 0 beat valid.
REQ-008 Port req0_data  in  data_depth*ArrL  requester 0 beat, element k at [k*data_depth +: data_depth].
REQ-009 Port req0_ready  out  1  requester 0 beat accepted when high together with req0_valid.
REQ-010 Ports req1_valid, req1_data, req1_ready SHALL match REQ-007 to REQ-009 for requester 1.
REQ-011 Port tree_din  out  data_depth*ArrL  operand vector driven to the external adder tree.
REQ-012 Port tree_sum  in  sumDepth  combinational sum of tree_din returned by the external adder tree.
REQ-013 Port out_valid  out  1  job result valid.
REQ-014 Port out_sum  out  accDepth  job total, the unsigned sum of all PASSES*ArrL elements.
REQ-015 Port out_id  out  1  index of the requester that owns the result.
REQ-016 Port out_ready  in  1  result consumed when high together with out_valid.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, ACCUM and DONE.
REQ-018 In IDLE, when either request is valid, the block SHALL grant one requester, load grant_id, clear beat_cnt and go to ACCUM on the next edge; no beat is accepted in IDLE.
REQ-019 Arbitration SHALL be round-robin: if both requests are valid, grant the requester not served last; the last-served pointer SHALL reset to 1, so req0 wins the first tie.
REQ-020 If only one request is valid, that requester SHALL be granted regardless of the pointer.
REQ-021 reqN_ready SHALL be high only in ACCUM and only when grant_id == N; it SHALL be combinational from state and grant_id, with no dependency on reqN_valid.
REQ-022 tree_din SHALL equal the granted requester's data in ACCUM and SHALL be all zeros in IDLE and DONE.
REQ-023 On each accepted beat, acc SHALL load tree_sum zero-extended if beat_cnt == 0, else acc SHALL become acc + tree_sum, and beat_cnt SHALL increment.
REQ-024 Cycles with the granted valid low SHALL leave acc and beat_cnt unchanged; the job SHALL NOT time out.
REQ-025 Acceptance of beat PASSES SHALL move the FSM to DONE on that edge; out_valid SHALL rise in the next cycle, giving latency 1 cycle from the last beat.
REQ-026 In DONE, out_valid SHALL be 1, out_sum SHALL equal acc, out_id SHALL equal grant_id, and these SHALL be held stable until out_ready is sampled high.
REQ-027 A handshake in DONE SHALL set the last-served pointer to grant_id and return the FSM to IDLE.
REQ-028 Re-grant SHALL take one IDLE cycle, so the minimum job period is PASSES+2 cycles.
REQ-029 accDepth SHALL be sufficient that no overflow can occur; no saturation logic is required.
REQ-030 The non-granted requester SHALL see ready low for the whole job; its valid and data SHALL be ignored.
REQ-031 The requester granted in IDLE SHALL stay granted even if its valid drops.

Reset
REQ-032 While rst is high, the block SHALL force: state IDLE, acc 0, beat_cnt 0, grant_id 0, last-served pointer 1, out_valid 0, out_sum 0, out_id 0, req0_ready 0, req1_ready 0 and tree_din 0.
REQ-033 Reset asserted mid-job SHALL discard the partial job; after release, the block SHALL behave exactly as after power-up.

Verification
REQ-034 Defaults, req0 only, 4 beats each with all elements 0xFF -> tree_sum 1020 per beat; out_valid rises 1 cycle after beat 4 with out_sum = 4080 and out_id = 0.
REQ-035 Both valid from reset, req0 beats 1,2,3,4 (each element) and req1 beats 5 (each element) -> first result out_id = 0, out_sum = 40; second result out_id = 1, out_sum = 80; tree_din never mixes the two requesters.
REQ-036 req0 valid with a 3-cycle gap after beat 2 -> ready stays high, acc unchanged during the gap, and the final sum equals the gap-free result.
REQ-037 out_ready held low for 5 cycles in DONE -> out_valid, out_sum and out_id stay constant, both readies stay 0, and the FSM returns to IDLE the cycle after out_ready rises.
REQ-038 rst pulsed after beat 2 of a req1 job -> all outputs 0 immediately; a following tie is granted to req0 and produces a correct fresh sum.
